// File: rtl/wr_arb_pkg.sv
// wr_arb_pkg: shared widths and request encoding for the register file write arbiter
package wr_arb_pkg;
    localparam int REG_W_DEF  = 5;
    localparam int DATA_W_DEF = 32;
    typedef enum logic [1:0] {REQ_NONE, REQ_WB, REQ_MD, REQ_IO} req_id_t;
endpackage

// File: rtl/wr_hold_slot.sv
// wr_hold_slot: one-entry holding buffer for a late register file write
//   valid/ready    : capture handshake, ready is simply "slot empty"
//   reg_in/data_in : entry captured on valid&ready; reg 0 entries are dropped
//   clr            : empties the slot (granted or superseded)
//   cmp_reg/match  : match flags a held entry whose nonzero reg equals cmp_reg
//   full/reg_q/data_q : held entry
module wr_hold_slot
    import wr_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              valid,
    input  logic [REG_W-1:0]  reg_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clr,
    input  logic [REG_W-1:0]  cmp_reg,
    output logic              ready,
    output logic              full,
    output logic [REG_W-1:0]  reg_q,
    output logic [DATA_W-1:0] data_q,
    output logic              match
);
    assign ready = ~full;
    assign match = full && cmp_reg != '0 && reg_q == cmp_reg;

    // clr and capture never coincide: clr needs full, capture needs ready
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            full   <= 1'b0;
            reg_q  <= '0;
            data_q <= '0;
        end else if (clr) begin
            full <= 1'b0;
        end else if (valid && ready && reg_in != '0) begin
            full   <= 1'b1;
            reg_q  <= reg_in;
            data_q <= data_in;
        end
    end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the register file write port between WB, MD and IO
//   wb_*          : pipeline writeback, default priority, must obey stall_wb
//   md_*, io_*    : late producers, each buffered in a one-entry slot
//   ctrl_write*, data_writeReg : registered write port, one cycle after grant
//   md/io_pending : slot occupancy for hazard/bypass logic
module regfile_wr_arbiter
    import wr_arb_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int REG_W        = REG_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [REG_W-1:0]  md_reg,
    input  logic [DATA_W-1:0] md_data,
    input  logic              io_valid,
    output logic              io_ready,
    input  logic [REG_W-1:0]  io_reg,
    input  logic [DATA_W-1:0] io_data,
    output logic              stall_wb,
    output logic              ctrl_writeEnable,
    output logic [REG_W-1:0]  ctrl_writeReg,
    output logic [DATA_W-1:0] data_writeReg,
    output logic              md_pending,
    output logic              io_pending
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic              md_full, io_full, md_match, io_match, md_clr, io_clr;
    logic              any_full, starved, slot_grant;
    logic [REG_W-1:0]  md_r, io_r;
    logic [DATA_W-1:0] md_d, io_d;
    logic [CW-1:0]     starve_cnt;
    req_id_t           last_grant, slot_pick, grant;

    wr_hold_slot #(.DATA_W(DATA_W), .REG_W(REG_W)) u_md (
        .clock(clock), .ctrl_reset(ctrl_reset), .valid(md_valid), .reg_in(md_reg),
        .data_in(md_data), .clr(md_clr), .cmp_reg(wb_reg), .ready(md_ready),
        .full(md_full), .reg_q(md_r), .data_q(md_d), .match(md_match)
    );

    wr_hold_slot #(.DATA_W(DATA_W), .REG_W(REG_W)) u_io (
        .clock(clock), .ctrl_reset(ctrl_reset), .valid(io_valid), .reg_in(io_reg),
        .data_in(io_data), .clr(io_clr), .cmp_reg(wb_reg), .ready(io_ready),
        .full(io_full), .reg_q(io_r), .data_q(io_d), .match(io_match)
    );

    always_comb begin
        any_full   = md_full | io_full;
        starved    = any_full && starve_cnt == CW'(STARVE_LIMIT);
        // on a tie, the slot that did not win last time goes first
        slot_pick  = (md_full && io_full) ? (last_grant == REQ_IO ? REQ_MD : REQ_IO)
                                          : (md_full ? REQ_MD : REQ_IO);
        grant      = starved ? slot_pick : wb_valid ? REQ_WB : any_full ? slot_pick : REQ_NONE;
        slot_grant = grant == REQ_MD || grant == REQ_IO;
        // a WB write to the same register makes the held entry stale
        md_clr     = grant == REQ_MD || (grant == REQ_WB && md_match);
        io_clr     = grant == REQ_IO || (grant == REQ_WB && io_match);
    end

    assign stall_wb   = starved;
    assign md_pending = md_full;
    assign io_pending = io_full;

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
            starve_cnt       <= '0;
            last_grant       <= REQ_IO;
        end else begin
            ctrl_writeEnable <= slot_grant || (grant == REQ_WB && wb_reg != '0);
            ctrl_writeReg    <= grant == REQ_WB ? wb_reg : grant == REQ_MD ? md_r
                              : grant == REQ_IO ? io_r : '0;
            data_writeReg    <= grant == REQ_WB ? wb_data : grant == REQ_MD ? md_d
                              : grant == REQ_IO ? io_d : '0;
            if (slot_grant)
                last_grant <= grant;
            starve_cnt <= (slot_grant || !any_full) ? '0
                        : (grant == REQ_WB && starve_cnt != CW'(STARVE_LIMIT)) ? starve_cnt + CW'(1)
                        : starve_cnt;
        end
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed scenarios plus randomized traffic against a reference model
module tb_regfile_wr_arbiter;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int LIMIT  = 4;

    logic              clock = 1'b0;
    logic              ctrl_reset = 1'b0;
    logic              wb_valid = 1'b0, md_valid = 1'b0, io_valid = 1'b0;
    logic [REG_W-1:0]  wb_reg = '0, md_reg = '0, io_reg = '0;
    logic [DATA_W-1:0] wb_data = '0, md_data = '0, io_data = '0;
    logic              md_ready, io_ready, stall_wb, ctrl_writeEnable, md_pending, io_pending;
    logic [REG_W-1:0]  ctrl_writeReg;
    logic [DATA_W-1:0] data_writeReg;

    int vectors = 0;
    int miscompares = 0;

    // reference model: slot contents, wait counter, tie-break memory, expected port
    bit                m_full [2];
    logic [REG_W-1:0]  m_reg  [2];
    logic [DATA_W-1:0] m_data [2];
    int                m_cnt;
    int                m_last;
    bit                e_we;
    logic [REG_W-1:0]  e_reg;
    logic [DATA_W-1:0] e_data;

    always #5 clock = ~clock;

    regfile_wr_arbiter #(.DATA_W(DATA_W), .REG_W(REG_W), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .md_valid(md_valid), .md_ready(md_ready), .md_reg(md_reg), .md_data(md_data),
        .io_valid(io_valid), .io_ready(io_ready), .io_reg(io_reg), .io_data(io_data),
        .stall_wb(stall_wb), .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .md_pending(md_pending), .io_pending(io_pending)
    );

    // advances the model across one rising edge; source 0 = MD, 1 = IO, 2 = WB, -1 = none
    task automatic model_edge();
        bit   vld [2];
        logic [REG_W-1:0]  r [2];
        logic [DATA_W-1:0] d [2];
        bit   any;
        int   pick, g;
        vld = '{md_valid, io_valid};
        r   = '{md_reg, io_reg};
        d   = '{md_data, io_data};
        if (!ctrl_reset) begin
            m_full = '{0, 0};
            m_cnt  = 0;
            m_last = 1;
            e_we   = 0; e_reg = '0; e_data = '0;
            return;
        end
        any  = m_full[0] || m_full[1];
        pick = (m_full[0] && m_full[1]) ? 1 - m_last : (m_full[0] ? 0 : 1);
        if (any && m_cnt == LIMIT) g = pick;
        else if (wb_valid)         g = 2;
        else if (any)              g = pick;
        else                       g = -1;
        e_we = 0;
        if (g == 2) begin
            e_we = wb_reg != 0; e_reg = wb_reg; e_data = wb_data;
        end else if (g >= 0) begin
            e_we = 1; e_reg = m_reg[g]; e_data = m_data[g];
        end
        if (g == 0 || g == 1) m_cnt = 0;
        else if (!any)        m_cnt = 0;
        else if (g == 2)      m_cnt = (m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1;
        if (g == 0 || g == 1) m_last = g;
        for (int s = 0; s < 2; s++) begin
            bit was_full = m_full[s];
            if (g == s) m_full[s] = 0;
            if (g == 2 && wb_reg != 0 && was_full && m_reg[s] == wb_reg) m_full[s] = 0;
            if (!was_full && vld[s] && r[s] != 0) begin
                m_full[s] = 1; m_reg[s] = r[s]; m_data[s] = d[s];
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        wb_valid = 0; md_valid = 0; io_valid = 0;
    endtask

    task automatic test_reset();
        ctrl_reset = 0;
        idle_inputs();
        tick(); tick();
        ctrl_reset = 1;
        vectors++; if (ctrl_writeEnable !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b want 0", ctrl_writeEnable); end
        vectors++; if (ctrl_writeReg !== '0) begin miscompares++; $display("FAIL reset_reg got %0d want 0", ctrl_writeReg); end
        vectors++; if (data_writeReg !== '0) begin miscompares++; $display("FAIL reset_data got %h want 0", data_writeReg); end
        vectors++; if ({md_ready, io_ready, stall_wb, md_pending, io_pending} !== 5'b11000) begin
            miscompares++; $display("FAIL reset_flags got %b want 11000", {md_ready, io_ready, stall_wb, md_pending, io_pending}); end
        wb_valid = 1; wb_reg = 7; wb_data = 32'hA5A5A5A5;
        tick();
        wb_valid = 0;
        vectors++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd7, 32'hA5A5A5A5}) begin
            miscompares++; $display("FAIL wb_write got we=%b reg=%0d data=%h want 1/7/a5a5a5a5", ctrl_writeEnable, ctrl_writeReg, data_writeReg); end
        vectors++; if ({md_ready, io_ready} !== 2'b11) begin miscompares++; $display("FAIL wb_ready got %b want 11", {md_ready, io_ready}); end
    endtask

    task automatic test_round_robin();
        md_valid = 1; md_reg = 3; md_data = 32'h11;
        io_valid = 1; io_reg = 4; io_data = 32'h22;
        tick();
        idle_inputs();
        vectors++; if ({md_pending, io_pending, ctrl_writeEnable} !== 3'b110) begin
            miscompares++; $display("FAIL rr_accept got pend=%b%b we=%b want 11/0", md_pending, io_pending, ctrl_writeEnable); end
        tick();
        vectors++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, md_pending, io_pending} !== {1'b1, 5'd3, 32'h11, 2'b01}) begin
            miscompares++; $display("FAIL rr_md got we=%b reg=%0d data=%h pend=%b%b want 1/3/11/01", ctrl_writeEnable, ctrl_writeReg, data_writeReg, md_pending, io_pending); end
        tick();
        vectors++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, md_pending, io_pending} !== {1'b1, 5'd4, 32'h22, 2'b00}) begin
            miscompares++; $display("FAIL rr_io got we=%b reg=%0d data=%h pend=%b%b want 1/4/22/00", ctrl_writeEnable, ctrl_writeReg, data_writeReg, md_pending, io_pending); end
        tick();
        vectors++; if (ctrl_writeEnable !== 1'b0) begin miscompares++; $display("FAIL rr_idle got we=%b want 0", ctrl_writeEnable); end
    endtask

    task automatic test_starvation();
        md_valid = 1; md_reg = 9; md_data = 32'h99;
        tick();
        md_valid = 0;
        for (int k = 1; k <= 10; k++) begin
            vectors++; if (stall_wb !== (k == 5)) begin miscompares++; $display("FAIL starve_stall_c%0d got %b want %b", k, stall_wb, k == 5); end
            if (k >= 2) begin
                vectors++;
                if ({ctrl_writeEnable, ctrl_writeReg} !== {1'b1, (k == 6) ? 5'd9 : 5'(20 + k - 1)}) begin
                    miscompares++; $display("FAIL starve_write_c%0d got we=%b reg=%0d want 1/%0d", k, ctrl_writeEnable, ctrl_writeReg, (k == 6) ? 9 : 20 + k - 1); end
            end
            wb_valid = 1; wb_reg = 5'(20 + k); wb_data = 32'(k);
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_supersede();
        md_valid = 1; md_reg = 12; md_data = 32'hC;
        tick();
        md_valid = 0; wb_valid = 1; wb_reg = 12; wb_data = 32'hBEEF;
        tick();
        wb_valid = 0;
        vectors++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, md_pending} !== {1'b1, 5'd12, 32'hBEEF, 1'b0}) begin
            miscompares++; $display("FAIL supersede_wb got we=%b reg=%0d data=%h pend=%b want 1/12/beef/0", ctrl_writeEnable, ctrl_writeReg, data_writeReg, md_pending); end
        tick();
        vectors++; if (ctrl_writeEnable !== 1'b0) begin miscompares++; $display("FAIL supersede_nomd got we=%b want 0", ctrl_writeEnable); end
        md_valid = 1; md_reg = 0; md_data = 32'h5;
        tick();
        md_valid = 0;
        vectors++; if ({md_pending, md_ready} !== 2'b01) begin miscompares++; $display("FAIL r0_slot got pend=%b rdy=%b want 0/1", md_pending, md_ready); end
        wb_valid = 1; wb_reg = 0; wb_data = 32'h77;
        tick();
        wb_valid = 0;
        vectors++; if (ctrl_writeEnable !== 1'b0) begin miscompares++; $display("FAIL r0_wb got we=%b want 0", ctrl_writeEnable); end
        tick();
        vectors++; if (ctrl_writeEnable !== 1'b0) begin miscompares++; $display("FAIL r0_after got we=%b want 0", ctrl_writeEnable); end
    endtask

    task automatic test_reset_midflight();
        md_valid = 1; md_reg = 5; md_data = 32'h55;
        io_valid = 1; io_reg = 6; io_data = 32'h66;
        tick();
        idle_inputs();
        wb_valid = 1; wb_reg = 1; wb_data = 32'h1;
        tick(); tick(); tick();
        vectors++; if ({stall_wb, md_pending, io_pending, ctrl_writeEnable} !== 4'b0111) begin
            miscompares++; $display("FAIL midrst_pre got stall=%b pend=%b%b we=%b want 0/11/1", stall_wb, md_pending, io_pending, ctrl_writeEnable); end
        wb_valid = 0; ctrl_reset = 0;
        tick();
        ctrl_reset = 1;
        vectors++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== '0) begin
            miscompares++; $display("FAIL midrst_port got we=%b reg=%0d data=%h want 0", ctrl_writeEnable, ctrl_writeReg, data_writeReg); end
        vectors++; if ({md_ready, io_ready, stall_wb, md_pending, io_pending} !== 5'b11000) begin
            miscompares++; $display("FAIL midrst_flags got %b want 11000", {md_ready, io_ready, stall_wb, md_pending, io_pending}); end
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++; if (ctrl_writeEnable !== 1'b0) begin miscompares++; $display("FAIL midrst_lost_c%0d got we=%b want 0", k, ctrl_writeEnable); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            ctrl_reset = ($urandom_range(0, 63) != 0);
            wb_valid = $urandom_range(0, 2) == 0;
            md_valid = $urandom_range(0, 1) == 0;
            io_valid = $urandom_range(0, 1) == 0;
            wb_reg = 5'($urandom_range(0, 3)); md_reg = 5'($urandom_range(0, 3)); io_reg = 5'($urandom_range(0, 3));
            wb_data = $urandom; md_data = $urandom; io_data = $urandom;
            tick();
            vectors++; if (ctrl_writeEnable !== e_we) begin miscompares++; $display("FAIL rand_we_%0d got %b want %b", n, ctrl_writeEnable, e_we); end
            if (e_we) begin
                vectors++; if ({ctrl_writeReg, data_writeReg} !== {e_reg, e_data}) begin
                    miscompares++; $display("FAIL rand_port_%0d got %0d/%h want %0d/%h", n, ctrl_writeReg, data_writeReg, e_reg, e_data); end
            end
            vectors++;
            if ({md_pending, io_pending, md_ready, io_ready, stall_wb} !==
                {m_full[0], m_full[1], !m_full[0], !m_full[1], (m_full[0] || m_full[1]) && m_cnt == LIMIT}) begin
                miscompares++; $display("FAIL rand_flags_%0d got pend=%b%b rdy=%b%b stall=%b want pend=%b%b cnt=%0d", n,
                    md_pending, io_pending, md_ready, io_ready, stall_wb, m_full[0], m_full[1], m_cnt); end
        end
        ctrl_reset = 1;
        idle_inputs();
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_round_robin();
        test_starvation();
        test_supersede();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
